// File: rtl/mem_port_arbiter.sv
// N-to-1 round-robin memory port arbiter: latches one master request and forwards it to a single slave.
// Optional slave timeout abort is compiled in with `define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int N_MASTERS      = 4,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 256,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS-1:0]          m_w_en,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  output logic [N_MASTERS-1:0]          m_ack,
  output logic                          m_err,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_req,
  output logic                          s_w_en,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic                          s_ack,
  input  logic [DATA_W-1:0]             s_rdata
);

  localparam int GW = $clog2(N_MASTERS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t               state, state_next;
  logic [GW-1:0]        last_grant;
  logic [GW-1:0]        grant_idx;
  logic [GW-1:0]        pick;
  logic [GW-1:0]        idx;
  logic                 found;
  logic                 grant_now;
  logic                 finish_now;
  logic                 timeout_now;
  logic [N_MASTERS-1:0] ack_next;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      idx = GW'((int'(last_grant) + k) % N_MASTERS);
      if (!found && m_req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (grant_now) begin
      wait_cnt <= '0;
    end else if (state == BUSY && !s_ack) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // The count reaches TIMEOUT_CYCLES on this BUSY cycle; a same-cycle s_ack still wins.
  assign timeout_now = (state == BUSY) && !s_ack && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  // No abort path: BUSY waits for s_ack indefinitely.
  assign timeout_now = (TIMEOUT_CYCLES < 1) && 1'b0;
`endif

  always_comb begin
    state_next = state;
    grant_now  = 1'b0;
    finish_now = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_next = BUSY;
          grant_now  = 1'b1;
        end
      end
      BUSY: begin
        if (s_ack || timeout_now) begin
          state_next = RESP;
          finish_now = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ack_next = '0;
    if (finish_now) ack_next[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= GW'(N_MASTERS - 1);
      grant_idx  <= '0;
      s_req      <= 1'b0;
      s_w_en     <= 1'b0;
      s_addr     <= '0;
      s_wdata    <= '0;
      m_ack      <= '0;
      m_err      <= 1'b0;
      m_rdata    <= '0;
    end else begin
      state <= state_next;
      m_ack <= ack_next;
      m_err <= finish_now && timeout_now;
      if (grant_now) begin
        grant_idx  <= pick;
        last_grant <= pick;
        s_req      <= 1'b1;
        s_w_en     <= m_w_en[pick];
        s_addr     <= m_addr[pick*ADDR_W +: ADDR_W];
        s_wdata    <= m_wdata[pick*DATA_W +: DATA_W];
      end
      if (finish_now) begin
        s_req <= 1'b0;
      end
      // Read data is only captured on a real completion of a read.
      if (finish_now && s_ack && !s_w_en) begin
        m_rdata <= s_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table of single-master transactions plus
// round-robin, stale-request, reset and slave-timeout sequences.
module tb_mem_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 256;
  localparam int TO = 8;
  localparam int EW = N + 1 + DW;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    m_req;
  logic [N-1:0]    m_w_en;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N-1:0]    m_ack;
  logic            m_err;
  logic [DW-1:0]   m_rdata;
  logic            s_req;
  logic            s_w_en;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic            s_ack;
  logic [DW-1:0]   s_rdata;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] sb_e;
  logic [DW-1:0] model_rdata;

  typedef struct {
    int            ch;
    logic          w_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            delay;
    logic [DW-1:0] rdata;
    logic [N-1:0]  exp_ack;
  } vec_t;

  vec_t vecs[5];

  // clock / reset
  always #5 clk = ~clk;

  mem_port_arbiter #(
    .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m_req(m_req), .m_w_en(m_w_en), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .s_req(s_req), .s_w_en(s_w_en), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every m_ack pulse consumes one expected {ack, err, rdata}
  always @(negedge clk) begin
    if (reset_n === 1'b1 && m_ack !== '0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_ack: got ack=%b want no ack", m_ack);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_ack",   DW'(m_ack), DW'(sb_e[EW-1 -: N]));
        check("sb_err",   DW'(m_err), DW'(sb_e[DW]));
        check("sb_rdata", m_rdata,    sb_e[DW-1:0]);
      end
    end
  end

  task automatic drive_chan(input int ch, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_w_en[ch]           = w;
    m_addr[ch*AW +: AW]  = a;
    m_wdata[ch*DW +: DW] = d;
  endtask

  task automatic wait_sreq(input string name);
    for (int c = 0; c < 10 && s_req !== 1'b1; c++) step();
    check(name, DW'(s_req), DW'(1'b1));
  endtask

  task automatic run_vec(input vec_t v);
    logic [DW-1:0] exp_rd;
    exp_rd = v.w_en ? model_rdata : v.rdata;
    m_req = '0;
    m_req[v.ch] = 1'b1;
    drive_chan(v.ch, v.w_en, v.addr, v.wdata);
    exp_q.push_back({v.exp_ack, 1'b0, exp_rd});
    step();
    // fields changed after grant must not reach the slave
    drive_chan(v.ch, ~v.w_en, ~v.addr, ~v.wdata);
    for (int j = 0; j <= v.delay; j++) begin
      check("vec_s_req",   DW'(s_req),  DW'(1'b1));
      check("vec_s_w_en",  DW'(s_w_en), DW'(v.w_en));
      check("vec_s_addr",  DW'(s_addr), DW'(v.addr));
      check("vec_s_wdata", s_wdata,     v.wdata);
      check("vec_no_ack",  DW'(m_ack),  DW'(4'b0000));
      s_ack   = (j == v.delay);
      s_rdata = (j == v.delay) ? v.rdata : {DW{1'b1}};
      step();
    end
    s_ack = 1'b0;
    check("vec_m_ack",   DW'(m_ack), DW'(v.exp_ack));
    check("vec_m_err",   DW'(m_err), DW'(1'b0));
    check("vec_s_req_0", DW'(s_req), DW'(1'b0));
    check("vec_rdata",   m_rdata,    exp_rd);
    model_rdata = exp_rd;
    m_req = '0;
    step();
    check("vec_ack_gone", DW'(m_ack), DW'(4'b0000));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_s_req",   DW'(s_req),   DW'(1'b0));
    check("rst_m_ack",   DW'(m_ack),   DW'(4'b0000));
    check("rst_m_err",   DW'(m_err),   DW'(1'b0));
    check("rst_m_rdata", m_rdata,      '0);
    check("rst_s_addr",  DW'(s_addr),  DW'(16'h0000));
    check("rst_s_wdata", s_wdata,      '0);
    check("rst_s_w_en",  DW'(s_w_en),  DW'(1'b0));
    model_rdata = '0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hold_ok;
    logic [AW-1:0] a;
    logic [N-1:0]  ack_v;
    int ch;

    vecs[0] = '{ch:2, w_en:1'b0, addr:16'h0040, wdata:'0, delay:0,
                rdata:{32{8'hA5}}, exp_ack:4'b0100};
    vecs[1] = '{ch:1, w_en:1'b1, addr:16'h1234, wdata:{8{32'hDEADBEEF}}, delay:5,
                rdata:{32{8'h5A}}, exp_ack:4'b0010};
    vecs[2] = '{ch:0, w_en:1'b0, addr:16'hFFFF, wdata:{DW{1'b1}}, delay:2,
                rdata:{4{64'h0123456789ABCDEF}}, exp_ack:4'b0001};
    vecs[3] = '{ch:3, w_en:1'b0, addr:16'h0000, wdata:'0, delay:1,
                rdata:{8{32'hCAFEF00D}}, exp_ack:4'b1000};
    vecs[4] = '{ch:2, w_en:1'b1, addr:16'h8000, wdata:{16{16'h0F0F}}, delay:0,
                rdata:{32{8'h33}}, exp_ack:4'b0100};

    m_req = '0; m_w_en = '0; m_addr = '0; m_wdata = '0;
    s_ack = 1'b0; s_rdata = '0;
    model_rdata = '0;
    reset_n = 1'b1;
    #2;
    do_reset();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // round-robin with all channels requesting continuously
    do_reset();
    for (int i = 0; i < N; i++) drive_chan(i, 1'b0, AW'(16'h0100 + i), '0);
    m_req = '1;
    for (int g = 0; g < 5; g++) begin
      ch    = g % N;
      a     = AW'(16'h0100 + ch);
      ack_v = N'(1) << ch;
      exp_q.push_back({ack_v, 1'b0, {16{a}}});
      wait_sreq("rr_grant_seen");
      check("rr_s_addr", DW'(s_addr), DW'(a));
      s_ack   = 1'b1;
      s_rdata = {16{s_addr}};
      step();
      s_ack = 1'b0;
      check("rr_m_ack", DW'(m_ack), DW'(ack_v));
      step();
    end
    m_req = '0;
    model_rdata = {16{16'h0100}};
    step();

    // stale request: only channel 3, held through its ack
    drive_chan(3, 1'b0, 16'h0333, '0);
    m_req = 4'b1000;
    step();
    check("stale_grant1", DW'(s_req), DW'(1'b1));
    exp_q.push_back({4'b1000, 1'b0, {8{32'h11112222}}});
    s_ack = 1'b1; s_rdata = {8{32'h11112222}};
    step();
    s_ack = 1'b0;
    check("stale_ack1", DW'(m_ack), DW'(4'b1000));
    step();
    check("stale_idle_sreq", DW'(s_req), DW'(1'b0));
    check("stale_idle_ack",  DW'(m_ack), DW'(4'b0000));
    step();
    check("stale_regrant", DW'(s_req),  DW'(1'b1));
    check("stale_addr",    DW'(s_addr), DW'(16'h0333));
    exp_q.push_back({4'b1000, 1'b0, {8{32'h33334444}}});
    s_ack = 1'b1; s_rdata = {8{32'h33334444}};
    step();
    s_ack = 1'b0;
    m_req = '0;
    model_rdata = {8{32'h33334444}};
    step();

`ifdef MEM_ARB_TIMEOUT_EN
    // slave never acks: abort after TO BUSY cycles
    drive_chan(1, 1'b0, 16'h0777, '0);
    m_req = 4'b0010;
    exp_q.push_back({4'b0010, 1'b1, model_rdata});
    step();
    for (int j = 0; j < TO; j++) begin
      check("to_s_req", DW'(s_req), DW'(1'b1));
      check("to_no_ack", DW'(m_ack), DW'(4'b0000));
      step();
    end
    check("to_m_ack",   DW'(m_ack), DW'(4'b0010));
    check("to_m_err",   DW'(m_err), DW'(1'b1));
    check("to_rdata",   m_rdata,    model_rdata);
    m_req = '0;
    step();
    check("to_err_gone", DW'(m_err), DW'(1'b0));
`endif

    // reset in BUSY; first grant afterwards goes to channel 0
    drive_chan(2, 1'b0, 16'h0222, '0);
    m_req = 4'b0100;
    step();
    check("rb_busy", DW'(s_req), DW'(1'b1));
`ifndef MEM_ARB_TIMEOUT_EN
    hold_ok = 1'b1;
    for (int j = 0; j < 100; j++) begin
      if (s_req !== 1'b1 || m_ack !== '0) hold_ok = 1'b0;
      step();
    end
    check("no_timeout_hold", DW'(hold_ok), DW'(1'b1));
`endif
    for (int i = 0; i < N; i++) drive_chan(i, 1'b0, AW'(16'h0500 + i), '0);
    m_req = '1;
    do_reset();
    check("post_rst_grant", DW'(s_req),  DW'(1'b1));
    check("post_rst_ch0",   DW'(s_addr), DW'(16'h0500));
    exp_q.push_back({4'b0001, 1'b0, {8{32'h5555AAAA}}});
    s_ack = 1'b1; s_rdata = {8{32'h5555AAAA}};
    step();
    s_ack = 1'b0;
    m_req = '0;
    step();
    step();

    check("sb_queue_empty", DW'(exp_q.size()), DW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised N-to-1 memory port arbiter. It is the successor to the single-master request/acknowledge memory port. It accepts up to N_MASTERS independent request/acknowledge channels, each with split read and write data buses in place of a shared bidirectional bus. It grants one channel at a time in round-robin order and forwards the latched request to one downstream memory slave. It sits between the multiplier's operand/result engines and the shared matrix memory.

## Interface
Parameters:
- N_MASTERS, 4, number of requesting channels (>= 2)
- ADDR_W, 16, address width
- DATA_W, 256, data width
- TIMEOUT_CYCLES, 64, maximum slave wait before abort (used only with MEM_ARB_TIMEOUT_EN; >= 1)

Ports:
- clk  in  1  single clock; all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- m_req  in  N_MASTERS  per-channel request; held high until that channel's m_ack
- m_w_en  in  N_MASTERS  per-channel write enable (1 = write, 0 = read)
- m_addr  in  N_MASTERS*ADDR_W  per-channel address; channel i at bits [i*ADDR_W +: ADDR_W]
- m_wdata  in  N_MASTERS*DATA_W  per-channel write data; same packing as m_addr
- m_ack  out  N_MASTERS  one-cycle completion pulse to the granted channel
- m_err  out  1  valid with m_ack; 1 = transaction aborted by timeout
- m_rdata  out  DATA_W  shared read data; valid while m_ack is high, held afterwards
- s_req  out  1  request to the slave
- s_w_en  out  1  latched write enable
- s_addr  out  ADDR_W  latched address
- s_wdata  out  DATA_W  latched write data
- s_ack  in  1  slave completion; sampled only in BUSY
- s_rdata  in  DATA_W  slave read data; valid with s_ack

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if any m_req bit is high, the arbiter selects a channel. The search starts at (last_grant+1) mod N_MASTERS and picks the first channel with m_req high.
  - It latches the grant index, w_en, addr and wdata into registers, updates last_grant, and moves to BUSY.
  - With no requests it stays in IDLE.
- BUSY: s_req=1, and s_w_en/s_addr/s_wdata come from the latch registers.
  - On sampled s_ack=1: capture s_rdata into m_rdata if the latched w_en=0. On a write, m_rdata is unchanged. Then go to RESP.
- RESP: m_ack[grant]=1 for exactly this cycle, s_req=0, and m_err is set as decided. Next state is always IDLE.
  - No arbitration happens in RESP, so the just-acked master's still-high m_req is not re-granted.
- The master must either drop m_req or present a new request (with new fields) in the cycle after m_ack.
- Changes to m_* fields after grant have no effect, because the fields are latched.
- s_ack is ignored in IDLE and RESP.
- Reset (including mid-transaction) forces the following, with any pending transaction dropped silently:
  - state=IDLE, last_grant=N_MASTERS-1 (so channel 0 wins first)
  - all outputs 0 (m_ack, m_err, m_rdata, s_req, s_w_en, s_addr, s_wdata)

## Timing
- All outputs are registered.
- With m_req sampled in IDLE at edge 0:
  - s_req is high after edge 0.
  - The slave may assert s_ack in the first s_req cycle (combinational slave allowed).
  - If s_ack is sampled at edge k, m_ack is high for the cycle after edge k and the arbiter is back in IDLE after edge k+1.
- Minimum request-to-ack latency is 2 cycles. Minimum spacing between grants is 3 cycles.
- s_req deasserts in the same cycle m_ack asserts.
- The round-robin guarantees every requesting channel is granted within N_MASTERS grants.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to BUSY and increments each BUSY cycle without s_ack.
  - When the count reaches TIMEOUT_CYCLES with s_ack still 0, the arbiter goes to RESP with m_err=1 and m_rdata unchanged.
  - An s_ack arriving on the timeout cycle wins: normal completion, m_err=0.
- Undefined: no counter. m_err is tied 0, and BUSY waits indefinitely for s_ack.

## Test plan
- Single read: channel 2 requests addr 0x0040, slave acks the first BUSY cycle with rdata 0xA5..A5. Expect s_req for 1 cycle, m_ack=4'b0100 one cycle later, m_rdata=0xA5..A5, total latency 2 cycles.
- Round-robin: all 4 channels request continuously after reset, each re-requesting the cycle after its ack. Expect grant order 0,1,2,3,0 and no channel granted twice before the others.
- Write then hold: channel 1 writes 0x1234 with data D, slave acks after 5 cycles. Expect s_addr=0x1234 and s_wdata=D stable for all 6 s_req cycles, and m_rdata unchanged.
- Reset mid-operation: assert reset_n=0 in BUSY. Expect s_req=0 and m_ack=0 immediately (asynchronously); after release, the first grant goes to channel 0.
- Timeout (macro defined, TIMEOUT_CYCLES=8): slave never acks. Expect m_ack with m_err=1 after 8 BUSY cycles. With the macro undefined, expect s_req to stay high indefinitely.
- Stale request: a master keeps m_req high through its ack cycle with no other requesters. Expect that master to be re-granted only from IDLE, 3 cycles after the previous grant.
